controle_entrada_saida: RTL and testbench
=========================================

# controle_entrada_saida

I/O sequencer for the single-cycle processor. It stalls the PC while an `in` or `pause` instruction waits for the user's confirm button. The button is synchronized and debounced; on confirmation the block latches the switch value and issues a one-cycle register-write pulse. It also holds the display register written by `out`, and sits between the control unit's `status`/`entradaSaidaControl` outputs and the PC, register file and board I/O.

## Interface
Parameters:
- `DATA_WIDTH`, 32, datapath word width.
- `SW_WIDTH`, 16, switch count; must be ≤ `DATA_WIDTH`.
- `DEBOUNCE_CYCLES`, 4, consecutive stable cycles required to accept a button change; ≥1.

Ports:
- `clock`  in  1  system clock, rising edge. One clock; reset is asynchronous and active-low.
- `reset`  in  1  asynchronous, active-low reset.
- `status`  in  1  halt request from control unit (`in`, `pause`).
- `entradaSaidaControl`  in  2  00 none, 01 `out`, 10 `in`, 11 treated as 00.
- `botao`  in  1  raw confirm button, active high, asynchronous to `clock`.
- `chaves`  in  `SW_WIDTH`  board switches.
- `dadoSaida`  in  `DATA_WIDTH`  value to display on `out`.
- `haltPC`  out  1  freeze PC and suppress datapath writes.
- `dadoEntrada`  out  `DATA_WIDTH`  latched switches, zero-extended.
- `habEscritaEntrada`  out  1  one-cycle register-file write enable for `dadoEntrada`.
- `display`  out  `DATA_WIDTH`  display register.
- `displayValido`  out  1  sticky; set by the first `out` after reset.

## Operation
- **Synchronizer:** two flops on `botao` produce `botaoSinc`.
- **Debounce:** a counter of width `$clog2(DEBOUNCE_CYCLES+1)` counts consecutive cycles in which `botaoSinc != confirmado`.
  - It clears whenever the two are equal.
  - On the edge where the count would reach `DEBOUNCE_CYCLES`, `confirmado` toggles and the counter clears.
- **FSM states:** OCIOSO, ESPERA, CAPTURA, SOLTA.
  - OCIOSO: if `status`=1, go to ESPERA and latch `ehEntrada` = (`entradaSaidaControl`==10).
  - ESPERA: if `confirmado`=1, go to CAPTURA and latch `dadoEntrada` = {zeros, `chaves`} only when `ehEntrada`=1. A `pause` leaves `dadoEntrada` unchanged.
  - CAPTURA: go to SOLTA unconditionally.
  - SOLTA: if `confirmado`=0, go to OCIOSO. One press yields exactly one event.
- **`haltPC`** (combinational):
  - OCIOSO and SOLTA: follows `status`.
  - ESPERA: 1.
  - CAPTURA: 0, so the PC advances on the CAPTURA edge.
- **`habEscritaEntrada`** = (state==CAPTURA) && `ehEntrada`.
- **`out`:** in OCIOSO with `entradaSaidaControl`==01 and `status`=0, `display` <= `dadoSaida` and `displayValido` <= 1 on the next edge. `out` never stalls, and is ignored in any other state.
- **Reset** (any time, including mid-wait), all cleared:
  - state = OCIOSO;
  - sync flops, counter, `confirmado` and `ehEntrada` = 0;
  - `dadoEntrada`, `display` = 0;
  - `displayValido` = 0.
- **Reset values:** `haltPC` = `status`, `habEscritaEntrada` = 0.

## Timing
- `botao` rising before edge k: `botaoSinc`=1 after edge k+1; `confirmado`=1 after edge k+1+`DEBOUNCE_CYCLES`; CAPTURA after edge k+2+`DEBOUNCE_CYCLES`. With the default, that is 6 edges.
- `habEscritaEntrada` and `haltPC`=0 last exactly one cycle (CAPTURA).
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles does not change `confirmado`.
- Button already held when `in` is decoded: the FSM passes ESPERA→CAPTURA on the next edge. This is permitted only after a release has returned the FSM to OCIOSO.
- A back-to-back `in` while the button is still held: `haltPC` stays 1 in SOLTA until the release is debounced, then ESPERA waits for a new press.
- `display` updates one edge after the `out` cycle.

## Configuration
- `CONTROLE_ES_DEBOUNCE_EN` defined: the debounce filter operates as above.
- Not defined:
  - `confirmado` = `botaoSinc` directly; no counter is instantiated.
  - CAPTURA comes after edge k+2.
  - `DEBOUNCE_CYCLES` is ignored.

## Test plan
- Reset low mid-ESPERA with `haltPC`=1 → immediately state OCIOSO and `haltPC`=`status`. After release, `display`=0, `displayValido`=0, `dadoEntrada`=0.
- `in` (`status`=1, ctrl=10), `chaves`=16'hA5A5, `botao` held 8 cycles from edge 10 → CAPTURA after edge 16; `dadoEntrada`=32'h0000A5A5; `habEscritaEntrada` high for exactly one cycle; `haltPC`=0 in that cycle only.
- `pause` (`status`=1, ctrl=00), press → `habEscritaEntrada` never asserts; `dadoEntrada` unchanged; `haltPC` drops for one cycle.
- `in`, `botao` pulses of 3 cycles (`DEBOUNCE_CYCLES`=4) → FSM remains in ESPERA and `haltPC` stays 1. With the macro undefined, the same pulse is accepted.
- Two consecutive `in` instructions, button held 40 cycles → exactly one write pulse; second write only after release plus a new press.
- `out` with `dadoSaida`=32'hDEADBEEF while OCIOSO → `display`=32'hDEADBEEF and `displayValido`=1 one edge later; `haltPC` stays 0.

Source files
------------

// File: rtl/controle_entrada_saida.sv
// I/O sequencer: stalls the PC for `in`/`pause` until the confirm button is accepted,
// latches switches for `in` and holds the `out` display register. Macro: CONTROLE_ES_DEBOUNCE_EN.
module controle_entrada_saida #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned SW_WIDTH        = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  status,
  input  logic [1:0]            entradaSaidaControl,
  input  logic                  botao,
  input  logic [SW_WIDTH-1:0]   chaves,
  input  logic [DATA_WIDTH-1:0] dadoSaida,
  output logic                  haltPC,
  output logic [DATA_WIDTH-1:0] dadoEntrada,
  output logic                  habEscritaEntrada,
  output logic [DATA_WIDTH-1:0] display,
  output logic                  displayValido
);

  typedef enum logic [1:0] {OCIOSO, ESPERA, CAPTURA, SOLTA} estado_t;

  estado_t               r_estado;
  estado_t               w_prox;
  logic                  r_sinc1;
  logic                  r_sinc2;
  logic                  w_confirmado;
  logic                  r_ehEntrada;
  logic [DATA_WIDTH-1:0] r_dadoEntrada;
  logic [DATA_WIDTH-1:0] r_display;
  logic                  r_displayValido;
  logic                  w_capturaDado;
  logic                  w_executaOut;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sinc1 <= 1'b0;
      r_sinc2 <= 1'b0;
    end else begin
      r_sinc1 <= botao;
      r_sinc2 <= r_sinc1;
    end
  end

`ifdef CONTROLE_ES_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ULT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cont;
  logic             r_confirmado;

  // Toggle on the edge where the count would reach DEBOUNCE_CYCLES.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cont       <= '0;
      r_confirmado <= 1'b0;
    end else if (r_sinc2 == r_confirmado) begin
      r_cont <= '0;
    end else if (r_cont == CNT_ULT) begin
      r_cont       <= '0;
      r_confirmado <= ~r_confirmado;
    end else begin
      r_cont <= r_cont + CNT_W'(1);
    end
  end

  assign w_confirmado = r_confirmado;
`else
  assign w_confirmado = r_sinc2;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_estado <= OCIOSO;
    else        r_estado <= w_prox;
  end

  always_comb begin
    w_prox = r_estado;
    haltPC = status;
    case (r_estado)
      OCIOSO: if (status) w_prox = ESPERA;
      ESPERA: begin
        haltPC = 1'b1;
        if (w_confirmado) w_prox = CAPTURA;
      end
      CAPTURA: begin
        haltPC = 1'b0;
        w_prox = SOLTA;
      end
      SOLTA: if (!w_confirmado) w_prox = OCIOSO;
      default: w_prox = OCIOSO;
    endcase
  end

  assign w_capturaDado = (r_estado == ESPERA) && w_confirmado && r_ehEntrada;
  assign w_executaOut  = (r_estado == OCIOSO) && (entradaSaidaControl == 2'b01) && !status;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ehEntrada     <= 1'b0;
      r_dadoEntrada   <= '0;
      r_display       <= '0;
      r_displayValido <= 1'b0;
    end else begin
      if (r_estado == OCIOSO && status)
        r_ehEntrada <= (entradaSaidaControl == 2'b10);
      if (w_capturaDado)
        r_dadoEntrada <= DATA_WIDTH'(chaves);
      if (w_executaOut) begin
        r_display       <= dadoSaida;
        r_displayValido <= 1'b1;
      end
    end
  end

  assign habEscritaEntrada = (r_estado == CAPTURA) && r_ehEntrada;
  assign dadoEntrada       = r_dadoEntrada;
  assign display           = r_display;
  assign displayValido     = r_displayValido;

endmodule

// File: tb/tb_controle_entrada_saida.sv
// Directed bench for controle_entrada_saida; latencies follow CONTROLE_ES_DEBOUNCE_EN.
module tb_controle_entrada_saida;

  localparam int DB = 4;
`ifdef CONTROLE_ES_DEBOUNCE_EN
  localparam int CAP = 3 + DB;
  localparam bit DEB = 1'b1;
`else
  localparam int CAP = 3;
  localparam bit DEB = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        status;
  logic [1:0]  entradaSaidaControl;
  logic        botao;
  logic [15:0] chaves;
  logic [31:0] dadoSaida;
  logic        haltPC;
  logic [31:0] dadoEntrada;
  logic        habEscritaEntrada;
  logic [31:0] display;
  logic        displayValido;

  int n_checks = 0;
  int n_falhas = 0;
  int pulsos, primeiro;

  controle_entrada_saida #(
    .DATA_WIDTH(32),
    .SW_WIDTH(16),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .status(status),
    .entradaSaidaControl(entradaSaidaControl),
    .botao(botao),
    .chaves(chaves),
    .dadoSaida(dadoSaida),
    .haltPC(haltPC),
    .dadoEntrada(dadoEntrada),
    .habEscritaEntrada(habEscritaEntrada),
    .display(display),
    .displayValido(displayValido)
  );

  always #5 clock = ~clock;

  task automatic checar(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
    n_checks++;
    if (obtido !== esperado) begin
      n_falhas++;
      $display("FAIL %s: obtido=%h esperado=%h", tag, obtido, esperado);
    end
  endtask

  task automatic ciclo();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; status = 1'b0; entradaSaidaControl = 2'b00; botao = 1'b0;
    chaves = '0; dadoSaida = '0;
    #2;
    checar("rst_halt", {31'd0, haltPC}, 32'd0);
    checar("rst_hab", {31'd0, habEscritaEntrada}, 32'd0);
    checar("rst_display", display, 32'd0);
    checar("rst_valido", {31'd0, displayValido}, 32'd0);
    ciclo();
    reset = 1'b1;
    ciclo();

    // `in` with A5A5, button held 8 cycles
    status = 1'b1; entradaSaidaControl = 2'b10; chaves = 16'hA5A5;
    #1;
    checar("in_ocioso_halt", {31'd0, haltPC}, 32'd1);
    ciclo();
    checar("in_espera_halt", {31'd0, haltPC}, 32'd1);
    botao = 1'b1;
    pulsos = 0; primeiro = 0;
    for (int n = 1; n <= 24; n++) begin
      ciclo();
      if (habEscritaEntrada) begin
        pulsos++;
        if (primeiro == 0) primeiro = n;
      end
      if (n == CAP - 1) checar("in_halt_antes", {31'd0, haltPC}, 32'd1);
      if (n == CAP) begin
        checar("in_halt_cap", {31'd0, haltPC}, 32'd0);
        checar("in_dado", dadoEntrada, 32'h0000A5A5);
        status = 1'b0; entradaSaidaControl = 2'b00;
      end
      if (n == CAP + 1) checar("in_halt_depois", {31'd0, haltPC}, 32'd0);
      if (n == 8) botao = 1'b0;
    end
    checar("in_pulsos", pulsos, 32'd1);
    checar("in_primeiro", primeiro, CAP);

    // `pause`: no write, dadoEntrada unchanged
    status = 1'b1; entradaSaidaControl = 2'b00; chaves = 16'h1234;
    ciclo();
    botao = 1'b1;
    pulsos = 0; primeiro = 0;
    for (int n = 1; n <= 24; n++) begin
      ciclo();
      if (habEscritaEntrada) pulsos++;
      if (!haltPC && primeiro == 0) begin
        primeiro = n;
        status = 1'b0;
      end
      if (n == 8) botao = 1'b0;
    end
    checar("pause_pulsos", pulsos, 32'd0);
    checar("pause_baixa", primeiro, CAP);
    checar("pause_dado", dadoEntrada, 32'h0000A5A5);

    // 3-cycle glitch on `in`
    status = 1'b1; entradaSaidaControl = 2'b10; chaves = 16'h5A5A;
    ciclo();
    botao = 1'b1;
    pulsos = 0;
    for (int n = 1; n <= 20; n++) begin
      ciclo();
      if (habEscritaEntrada) pulsos++;
      if (n == 3) botao = 1'b0;
    end
    checar("glitch_pulsos", pulsos, DEB ? 32'd0 : 32'd1);
    checar("glitch_dado", dadoEntrada, DEB ? 32'h0000A5A5 : 32'h00005A5A);
    checar("glitch_espera_halt", {31'd0, haltPC}, 32'd1);

    // asynchronous reset while waiting in ESPERA
    status = 1'b0; reset = 1'b0;
    #1;
    checar("rstmeio_halt", {31'd0, haltPC}, 32'd0);
    checar("rstmeio_dado", dadoEntrada, 32'd0);
    checar("rstmeio_hab", {31'd0, habEscritaEntrada}, 32'd0);
    ciclo();
    reset = 1'b1;
    ciclo();
    checar("rstmeio_display", display, 32'd0);
    checar("rstmeio_valido", {31'd0, displayValido}, 32'd0);

    // back-to-back `in`, button held 40 cycles
    status = 1'b1; entradaSaidaControl = 2'b10; chaves = 16'h00C3; botao = 1'b1;
    pulsos = 0;
    for (int n = 1; n <= 40; n++) begin
      ciclo();
      if (habEscritaEntrada) pulsos++;
    end
    checar("b2b_pulsos_seg", pulsos, 32'd1);
    checar("b2b_dado1", dadoEntrada, 32'h000000C3);
    checar("b2b_solta_halt", {31'd0, haltPC}, 32'd1);
    botao = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      ciclo();
      if (habEscritaEntrada) pulsos++;
    end
    checar("b2b_pulsos_solto", pulsos, 32'd1);
    checar("b2b_espera_halt", {31'd0, haltPC}, 32'd1);
    chaves = 16'h003C; botao = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      ciclo();
      if (habEscritaEntrada) begin
        pulsos++;
        status = 1'b0; entradaSaidaControl = 2'b00;
      end
      if (n == 12) botao = 1'b0;
    end
    checar("b2b_pulsos_total", pulsos, 32'd2);
    checar("b2b_dado2", dadoEntrada, 32'h0000003C);

    // `out` while idle
    status = 1'b0; entradaSaidaControl = 2'b01; dadoSaida = 32'hDEADBEEF;
    #1;
    checar("out_halt", {31'd0, haltPC}, 32'd0);
    checar("out_antes", display, 32'd0);
    ciclo();
    entradaSaidaControl = 2'b00; dadoSaida = 32'h12345678;
    checar("out_display", display, 32'hDEADBEEF);
    checar("out_valido", {31'd0, displayValido}, 32'd1);
    ciclo();
    checar("out_mantem", display, 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_falhas);
    $finish;
  end

endmodule
